picoregs_ctrl: RTL and testbench

Controller that sits between the RISC-V core's register-file request interface and the dual-port 32×32 register RAM (synchronous read, one-cycle latency, normal write mode).
- Clears all 32 registers after reset.
- Services rs1/rs2 read requests by using both RAM ports at once, and holds the result until the core takes it.
- Arbitrates rd writebacks onto port A.
- Makes x0 read zero and ignore writes.

The parent instantiates it next to the RAM.

---
 rtl/picoregs_pkg.sv | 15 +
 rtl/picoregs_if.sv | 28 ++
 rtl/picoregs_ctrl.sv | 132 +++++++++++++
 tb/tb_picoregs_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/picoregs_pkg.sv
// Shared widths and state encoding for the register-file controller.
package picoregs_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/picoregs_if.sv
// Core-side register-file port: operand read request/response and rd writeback.
interface picoregs_if #(
    parameter int XLEN = picoregs_pkg::XLEN,
    parameter int AW   = picoregs_pkg::AW
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_rs1;
    logic [AW-1:0]   req_rs2;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rs1_data;
    logic [XLEN-1:0] rsp_rs2_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_rd;
    logic [XLEN-1:0] wr_data;

    modport master (
        output req_valid, req_rs1, req_rs2, rsp_ready, wr_valid, wr_rd, wr_data,
        input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, wr_ready
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, rsp_ready, wr_valid, wr_rd, wr_data,
        output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, wr_ready
    );
endinterface

// File: rtl/picoregs_ctrl.sv
// Sequences the dual-port register RAM: clear after reset, paired operand reads,
// rd writebacks on port A, x0 hard-wired to zero.
//
// state | meaning
// INIT  | clearing two registers per cycle, cnt = 0..15
// IDLE  | accepting writebacks (priority) or an operand read
// READ  | RAM ports idle, capturing douta/doutb
// RESP  | operands held until rsp_ready; writebacks still accepted
module picoregs_ctrl #(
    parameter int XLEN = picoregs_pkg::XLEN,
    parameter int AW   = picoregs_pkg::AW
) (
    input  logic            clk,
    input  logic            reset,
    picoregs_if.slave       core,
    output logic            ram_cea,
    output logic            ram_ceb,
    output logic            ram_wrea,
    output logic            ram_wreb,
    output logic [AW-1:0]   ram_ada,
    output logic [AW-1:0]   ram_adb,
    output logic [XLEN-1:0] ram_dina,
    output logic [XLEN-1:0] ram_dinb,
    input  logic [XLEN-1:0] ram_douta,
    input  logic [XLEN-1:0] ram_doutb
);
    import picoregs_pkg::*;

    state_t          state;
    logic [AW-2:0]   cnt;
    logic            rs1_zero;
    logic            rs2_zero;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;

    assign core.rsp_valid    = rsp_valid_q;
    assign core.rsp_rs1_data = rs1_q;
    assign core.rsp_rs2_data = rs2_q;

    // RAM controls must follow the handshake in the same cycle, so they are
    // decoded from state; reset forces every enable low.
    always_comb begin
        ram_cea       = 1'b0;
        ram_ceb       = 1'b0;
        ram_wrea      = 1'b0;
        ram_wreb      = 1'b0;
        ram_ada       = '0;
        ram_adb       = '0;
        ram_dina      = '0;
        ram_dinb      = '0;
        core.wr_ready  = 1'b0;
        core.req_ready = 1'b0;
        if (!reset) begin
            case (state)
                INIT: begin
                    ram_cea  = 1'b1;
                    ram_ceb  = 1'b1;
                    ram_wrea = 1'b1;
                    ram_wreb = 1'b1;
                    ram_ada  = {cnt, 1'b0};
                    ram_adb  = {cnt, 1'b1};
                end
                IDLE: begin
                    core.wr_ready  = 1'b1;
                    core.req_ready = !core.wr_valid;
                    if (core.wr_valid) begin
                        ram_cea  = 1'b1;
                        ram_wrea = (core.wr_rd != '0);
                        ram_ada  = core.wr_rd;
                        ram_dina = core.wr_data;
                    end else if (core.req_valid) begin
                        ram_cea = 1'b1;
                        ram_ceb = 1'b1;
                        ram_ada = core.req_rs1;
                        ram_adb = core.req_rs2;
                    end
                end
                RESP: begin
                    core.wr_ready = 1'b1;
                    if (core.wr_valid) begin
                        ram_cea  = 1'b1;
                        ram_wrea = (core.wr_rd != '0);
                        ram_ada  = core.wr_rd;
                        ram_dina = core.wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            cnt         <= '0;
            rs1_zero    <= 1'b0;
            rs2_zero    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) state <= IDLE;
                end
                IDLE: begin
                    if (!core.wr_valid && core.req_valid) begin
                        rs1_zero <= (core.req_rs1 == '0);
                        rs2_zero <= (core.req_rs2 == '0);
                        state    <= READ;
                    end
                end
                READ: begin
                    rs1_q       <= rs1_zero ? '0 : ram_douta;
                    rs2_q       <= rs2_zero ? '0 : ram_doutb;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (core.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_picoregs_ctrl.sv
// Scoreboard bench for picoregs_ctrl with a behavioural dual-port RAM.
module tb_picoregs_ctrl;
    import picoregs_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    picoregs_if #(.XLEN(32), .AW(5)) core_if();

    logic        ram_cea, ram_ceb, ram_wrea, ram_wreb;
    logic [4:0]  ram_ada, ram_adb;
    logic [31:0] ram_dina, ram_dinb, ram_douta, ram_doutb;

    picoregs_ctrl #(.XLEN(32), .AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .core      (core_if),
        .ram_cea   (ram_cea),
        .ram_ceb   (ram_ceb),
        .ram_wrea  (ram_wrea),
        .ram_wreb  (ram_wreb),
        .ram_ada   (ram_ada),
        .ram_adb   (ram_adb),
        .ram_dina  (ram_dina),
        .ram_dinb  (ram_dinb),
        .ram_douta (ram_douta),
        .ram_doutb (ram_doutb)
    );

    // Dual-port synchronous RAM, normal write mode, preloaded with junk.
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | i;
        ram_douta = 32'h0;
        ram_doutb = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_cea) begin
            if (ram_wrea) begin mem[ram_ada] <= ram_dina; ram_douta <= ram_dina; end
            else ram_douta <= mem[ram_ada];
        end
        if (ram_ceb) begin
            if (ram_wreb) begin mem[ram_adb] <= ram_dinb; ram_doutb <= ram_dinb; end
            else ram_doutb <= mem[ram_adb];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_acc_cyc = 0;
    int rd_acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        int          due;
        string       name;
    } rsp_t;
    rsp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every cycle the response is presented, pops on handshake.
    logic prev_hold = 1'b0;
    always @(negedge clk) begin
        if (core_if.rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
                if (!prev_hold) chk({sb[0].name, "_latency"}, cyc, sb[0].due);
                chk({sb[0].name, "_rs1"}, core_if.rsp_rs1_data, sb[0].d1);
                chk({sb[0].name, "_rs2"}, core_if.rsp_rs2_data, sb[0].d2);
                if (core_if.rsp_ready) void'(sb.pop_front());
            end
        end
        prev_hold = core_if.rsp_valid && !core_if.rsp_ready;
    end

    // Called at a point just after a rising edge; leaves reset deasserted and
    // the controller one cycle into IDLE.
    task automatic reset_and_init();
        int seen [32];
        reset = 1'b1;
        @(negedge clk);
        chk("rst_enables", {28'h0, ram_cea, ram_ceb, ram_wrea, ram_wreb}, 32'h0);
        chk("rst_ready", {30'h0, core_if.req_ready, core_if.wr_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, core_if.rsp_valid}, 32'h0);
        chk("rst_rsp_data", core_if.rsp_rs1_data | core_if.rsp_rs2_data, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int a = 0; a < 32; a++) seen[a] = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_enables", {28'h0, ram_cea, ram_ceb, ram_wrea, ram_wreb}, 32'hF);
            chk("init_data", ram_dina | ram_dinb, 32'h0);
            chk("init_ready", {30'h0, core_if.req_ready, core_if.wr_ready}, 32'h0);
            seen[ram_ada]++;
            seen[ram_adb]++;
        end
        for (int a = 0; a < 32; a++) chk($sformatf("init_cover_x%0d", a), seen[a], 1);
        @(negedge clk);
        chk("post_init_ready", {30'h0, core_if.req_ready, core_if.wr_ready}, 32'h3);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [31:0] data);
        int n = 0;
        core_if.wr_valid = 1'b1;
        core_if.wr_rd    = rd;
        core_if.wr_data  = data;
        @(negedge clk);
        while (!core_if.wr_ready && n < 20) begin n++; @(negedge clk); end
        if (!core_if.wr_ready) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: got wr_ready=0 expected 1 within 20 cycles");
        end else begin
            wr_acc_cyc = cyc;
            chk("wr_cea", {31'h0, ram_cea}, 32'h1);
            chk("wr_wrea", {31'h0, ram_wrea}, {31'h0, rd != 5'd0});
            chk("wr_ada", {27'h0, ram_ada}, {27'h0, rd});
            chk("wr_dina", ram_dina, data);
        end
        @(posedge clk);
        #1 core_if.wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] e1, input logic [31:0] e2, input string name);
        int n = 0;
        core_if.req_valid = 1'b1;
        core_if.req_rs1   = rs1;
        core_if.req_rs2   = rs2;
        @(negedge clk);
        while (!core_if.req_ready && n < 20) begin n++; @(negedge clk); end
        if (!core_if.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_req_timeout: got req_ready=0 expected 1 within 20 cycles", name);
        end else begin
            rd_acc_cyc = cyc;
            sb.push_back('{e1, e2, cyc + 2, name});
            chk({name, "_rd_enables"}, {28'h0, ram_cea, ram_ceb, ram_wrea, ram_wreb}, 32'hC);
            chk({name, "_rd_addr"}, {22'h0, ram_ada, ram_adb}, {22'h0, rs1, rs2});
        end
        @(posedge clk);
        #1 core_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin n++; @(posedge clk); end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        core_if.req_valid = 1'b0;
        core_if.req_rs1   = '0;
        core_if.req_rs2   = '0;
        core_if.rsp_ready = 1'b1;
        core_if.wr_valid  = 1'b0;
        core_if.wr_rd     = '0;
        core_if.wr_data   = '0;
        #1;
        reset_and_init();

        // write then read on the following cycle, rs2 = x0
        do_write(5'd5, 32'hDEADBEEF);
        do_read(5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "t_wr_rd");
        drain();

        // x0 ignores writes
        do_write(5'd0, 32'hFFFFFFFF);
        do_read(5'd0, 5'd0, 32'h0, 32'h0, "t_x0");
        drain();

        // simultaneous write and read: write first, read one cycle later
        fork
            do_write(5'd9, 32'h55AA1234);
            do_read(5'd9, 5'd5, 32'h55AA1234, 32'hDEADBEEF, "t_collide");
        join
        chk("collide_order", rd_acc_cyc, wr_acc_cyc + 1);
        drain();

        // held response unaffected by a write in RESP
        do_write(5'd7, 32'h0000AAAA);
        core_if.rsp_ready = 1'b0;
        do_read(5'd7, 5'd7, 32'h0000AAAA, 32'h0000AAAA, "t_hold");
        @(posedge clk);
        #1;
        chk("hold_valid", {31'h0, core_if.rsp_valid}, 32'h1);
        do_write(5'd7, 32'h00001234);
        repeat (4) @(posedge clk);
        #1 core_if.rsp_ready = 1'b1;
        drain();
        do_read(5'd7, 5'd0, 32'h00001234, 32'h0, "t_after_hold");
        drain();

        // reset while in READ drops the read and re-clears the RAM
        do_read(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "t_dropped");
        sb.delete();
        reset_and_init();
        chk("reset_rsp_valid", {31'h0, core_if.rsp_valid}, 32'h0);
        do_read(5'd5, 5'd9, 32'h0, 32'h0, "t_recleared");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
